// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch and decode stages: widths, reset PC,
// canonical NOP and base opcode encodings.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH x W circular buffer with combinational head.
// Flush wins over push and pop; push and pop together are legal even when full.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC owner, credit-limited imem requests, prefetch FIFO to decoder.
// Optional misaligned-redirect fault enabled by IFETCH_MISALIGN_CHK_EN.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int               XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int               FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
`ifdef IFETCH_MISALIGN_CHK_EN
  , output logic            fetch_fault
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [INST_W-1:0] fifo_head;
  logic [XLEN-1:0] target;
  logic [CW:0]     used;
  logic            fetch_blocked;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d;

  assign target = redirect_pc;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fetch_blocked = fault_q;
  assign fetch_fault   = fault_q;
`else
  assign target        = redirect_pc & ~XLEN'(3);
  assign fetch_blocked = 1'b0;
`endif

  // Only issue when every outstanding request is guaranteed a FIFO slot.
  assign used           = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && !fetch_blocked &&
                          (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = target;
      head_pc_d  = target;
      discard_d  = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (pop)      head_pc_d  = head_pc_q + XLEN'(INST_BYTES);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (imem_rsp_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = fifo_head;
  assign inst_pc    = head_pc_q;

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight_q != '0));
  a_discard_le_inflight: assert property (@(posedge clk) disable iff (rst)
    discard_q <= inflight_q);
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic checked
// against an epoch-tagged request/buffer model of the fetch stage.
module tb_instruction_fetch;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  instruction_fetch #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef IFETCH_MISALIGN_CHK_EN
    , .fetch_fault  (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          tag;
    int          due;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t pending[$];
  ent_t buffered[$];

  int          errors, checks;
  int          cyc, epoch, fires, delivered, pops_since_redir;
  int          rdy_pct, ir_pct, lat_min, lat_max;
  logic [31:0] exp_addr, first_pc, first_data;
  logic        exp_fault;
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %0s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("rst_fault", fetch_fault, 0);
`endif
    pending.delete();
    buffered.delete();
    exp_addr         = RST_PC;
    exp_fault        = 1'b0;
    pops_since_redir = 0;
    epoch++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc++;
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance the model.
  task automatic step(input logic redir, input logic [31:0] tgt);
    req_t        r;
    ent_t        e;
    logic        exp_rv, fire, rsp, keep;
    logic [31:0] tgt_eff;
    int          due;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    inst_ready     = ($urandom_range(0, 99) < ir_pct);
    rsp            = (pending.size() != 0) && (pending[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pending[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !redir && !exp_fault && ((pending.size() + buffered.size()) < DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, exp_addr);
    chk("inst_valid", inst_valid, buffered.size() != 0);
    if (buffered.size() != 0) begin
      chk("inst_pc", inst_pc, buffered[0].pc);
      chk("inst_data", inst_data, buffered[0].data);
    end
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("fault", fetch_fault, exp_fault);
`endif
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    fire = exp_rv && imem_req_ready;
    if (fire) fires++;
    keep = 1'b0;
    if (rsp) begin
      r    = pending.pop_front();
      keep = (r.tag == epoch) && !redir;
    end
    if (redir) begin
      buffered.delete();
      epoch++;
      tgt_eff = tgt;
`ifdef IFETCH_MISALIGN_CHK_EN
      exp_fault = (tgt[1:0] != 2'b00);
`else
      tgt_eff[1:0] = 2'b00;
`endif
      exp_addr         = tgt_eff;
      pops_since_redir = 0;
    end else begin
      if (inst_ready && buffered.size() != 0) begin
        if (pops_since_redir == 0) begin
          first_pc   = inst_pc;
          first_data = inst_data;
        end
        pops_since_redir++;
        delivered++;
        buffered.delete(0);
      end
      if (keep) begin
        e.pc   = r.addr;
        e.data = mem_word(r.addr);
        buffered.push_back(e);
      end
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (pending.size() != 0 && pending[$].due >= due) due = pending[$].due + 1;
      r.addr = exp_addr;
      r.tag  = epoch;
      r.due  = due;
      pending.push_back(r);
      exp_addr = exp_addr + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] tgt;
    logic        redir;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    errors = 0; checks = 0; cyc = 0; epoch = 0; fires = 0; delivered = 0;
    pops_since_redir = 0; exp_fault = 1'b0; exp_addr = RST_PC;
    first_pc = '0; first_data = '0; obs_req_valid = 1'b0; obs_req_addr = '0; found = 1'b0;
    rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;

    // 1: streaming from reset
    do_reset();
    delivered = 0;
    repeat (30) step(1'b0, 32'h0);
    chk("t1_first_pc", first_pc, RST_PC);
    chk("t1_first_data", first_data, mem_word(RST_PC));
    chk("t1_throughput", delivered >= 15, 1);

    // 2: decoder stalled fills exactly DEPTH credits
    ir_pct = 0;
    step(1'b1, 32'h40);
    fires = 0;
    repeat (10) step(1'b0, 32'h0);
    chk("t2_fires", fires, DEPTH);
    chk("t2_req_off", obs_req_valid, 0);
    ir_pct = 100;
    repeat (10) step(1'b0, 32'h0);
    chk("t2_first_pc", first_pc, 32'h40);

    // 3: two late responses dropped after redirect
    lat_min = 3; lat_max = 3; ir_pct = 0;
    step(1'b1, 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    ir_pct = 100;
    step(1'b1, 32'h100);
    repeat (15) step(1'b0, 32'h0);
    chk("t3_first_pc", first_pc, 32'h100);
    chk("t3_first_data", first_data, mem_word(32'h100));

    // 4: response, pop and redirect in one cycle
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'h80);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (buffered.size() != 0 && pending.size() != 0 && pending[0].due <= cyc) begin
        step(1'b1, 32'h100);
        found = 1'b1;
      end else begin
        step(1'b0, 32'h0);
      end
    end
    chk("t4_found", found, 1);
    step(1'b0, 32'h0);
    chk("t4_req_valid", obs_req_valid, 1);
    chk("t4_req_addr", obs_req_addr, 32'h100);
    repeat (10) step(1'b0, 32'h0);
    chk("t4_first_pc", first_pc, 32'h100);

    // 5: reset mid-burst
    lat_min = 3; lat_max = 3; ir_pct = 0;
    step(1'b1, 32'h300);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 32'h0);
      if (pending.size() == 2) found = 1'b1;
    end
    chk("t5_two_inflight", found, 1);
    do_reset();
    lat_min = 1; lat_max = 1; ir_pct = 100;
    step(1'b0, 32'h0);
    chk("t5_req_valid", obs_req_valid, 1);
    chk("t5_req_addr", obs_req_addr, RST_PC);
    repeat (10) step(1'b0, 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
    // 6: misaligned redirect faults, aligned redirect recovers
    step(1'b1, 32'h102);
    repeat (6) step(1'b0, 32'h0);
    chk("t6_fault_set", fetch_fault, 1);
    chk("t6_no_req", obs_req_valid, 0);
    chk("t6_addr_held", obs_req_addr, 32'h102);
    step(1'b1, 32'h200);
    step(1'b0, 32'h0);
    chk("t6_fault_clr", fetch_fault, 0);
    chk("t6_req_valid", obs_req_valid, 1);
    chk("t6_req_addr", obs_req_addr, 32'h200);
    repeat (10) step(1'b0, 32'h0);
`else
    // low address bits of a redirect are ignored without the fault check
    step(1'b1, 32'h102);
    step(1'b0, 32'h0);
    chk("mask_req_addr", obs_req_addr, 32'h100);
    repeat (10) step(1'b0, 32'h0);
    chk("mask_first_pc", first_pc, 32'h100);
`endif

    // PC wrap-around at the top of the address space
    step(1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b0, 32'h0);
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

    // random traffic
    rdy_pct = 70; ir_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
      else                           tgt = $urandom_range(0, 1023) << 2;
      step(redir, tgt);
    end
    rdy_pct = 100; ir_pct = 100;
    repeat (20) step(1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
